// File: rtl/apple1_kbd_pkg.sv
// Shared constants and bus request type for the Apple-1 keyboard port.
package apple1_kbd_pkg;
  localparam logic [1:0] KBD_ADDR   = 2'b00;
  localparam logic [1:0] KBDCR_ADDR = 2'b01;
  localparam logic [7:0] KBD_EMPTY  = 8'h80;
  localparam int KBDCR_READY_BIT = 7;
  localparam int KBDCR_OVF_BIT   = 6;

  typedef struct packed {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
  } bus_req_t;
endpackage

// File: rtl/kbd_fifo.sv
// Synchronous type-ahead FIFO; a pop frees a slot for a same-cycle push.
module kbd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/apple1_kbd_port.sv
// Apple-1 KBD/KBDCR registers: key capture into a FIFO, pop on completed KBD read.
module apple1_kbd_port
  import apple1_kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] ascii_code,
  input  logic       ascii_new,
  input  logic       phi2,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] addr,
  output logic [7:0] data_out,
  output logic       overflow
);
  bus_req_t   bus;
  logic [2:0] phi2_pipe;  // [1:0] synchronizer, [2] edge history
  logic       phi2_s, phi2_fall;
  logic [1:0] new_pipe;
  logic [6:0] code_q;
  logic       key_push;
  logic       rd_kbd_pend, rd_cr_pend;
  logic       fifo_pop, empty, full;
  logic [6:0] head;

  assign bus       = '{cs: cs, rw: rw, addr: addr};
  assign phi2_s    = phi2_pipe[1];
  assign phi2_fall = phi2_pipe[2] & ~phi2_pipe[1];
  assign key_push  = new_pipe[0] & ~new_pipe[1];
  assign fifo_pop  = phi2_fall & rd_kbd_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phi2_pipe <= '0;
      new_pipe  <= '0;
      code_q    <= '0;
    end else begin
      phi2_pipe <= {phi2_pipe[1:0], phi2};
      new_pipe  <= {new_pipe[0], ascii_new};
      code_q    <= ascii_code;
    end
  end

  // Reads are latched during phi2 high and take effect only once phi2 falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_kbd_pend <= 1'b0;
      rd_cr_pend  <= 1'b0;
    end else if (phi2_fall) begin
      rd_kbd_pend <= 1'b0;
      rd_cr_pend  <= 1'b0;
    end else if (phi2_s && bus.cs && bus.rw) begin
      if (bus.addr == KBD_ADDR)   rd_kbd_pend <= 1'b1;
      if (bus.addr == KBDCR_ADDR) rd_cr_pend  <= 1'b1;
    end
  end

  // A fresh drop wins over a same-cycle KBDCR clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            overflow <= 1'b0;
    else if (key_push && full && !fifo_pop) overflow <= 1'b1;
    else if (phi2_fall && rd_cr_pend)     overflow <= 1'b0;
  end

  kbd_fifo #(.WIDTH(7), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_push),
    .pop   (fifo_pop),
    .din   (code_q),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    data_out = 8'h00;
    if (!bus.addr[1]) begin
      if (bus.addr == KBD_ADDR) begin
        data_out = empty ? KBD_EMPTY : {1'b1, head};
      end else begin
        data_out[KBDCR_READY_BIT] = ~empty;
        data_out[KBDCR_OVF_BIT]   = overflow;
      end
    end
  end
endmodule

// File: tb/tb_apple1_kbd_port.sv
// Randomized and directed bench for apple1_kbd_port against a queue-based model.
module tb_apple1_kbd_port;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] ascii_code;
  logic       ascii_new;
  logic       phi2, cs, rw;
  logic [1:0] addr;
  logic [7:0] data_out;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] m_q[$];
  bit         m_ovf;

  always #5 clk = ~clk;

  apple1_kbd_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ascii_code(ascii_code), .ascii_new(ascii_new),
    .phi2(phi2), .cs(cs), .rw(rw), .addr(addr),
    .data_out(data_out), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [1:0] a);
    if (a[1])      return 8'h00;
    if (a == 2'b1) return {m_q.size() != 0, m_ovf, 6'b0};
    if (m_q.size() == 0) return 8'h80;
    return {1'b1, m_q[0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_key(input logic [6:0] code);
    @(negedge clk);
    ascii_code = code;
    ascii_new  = 1'b1;
    repeat (2) @(negedge clk);
    ascii_new = 1'b0;
    repeat (3) @(negedge clk);
    if (m_q.size() < DEPTH) m_q.push_back(code);
    else                    m_ovf = 1'b1;
    chk("push_ovf", {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  // One 6502 access; read data must stay stable for the whole phi2-high window.
  task automatic bus_cycle(input logic [1:0] a, input logic r, input string tag);
    logic [7:0] e;
    @(negedge clk);
    addr = a; rw = r; cs = 1'b1; phi2 = 1'b1;
    e = exp_data(a);
    repeat (3) @(negedge clk);
    chk({tag, "_early"}, data_out, e);
    repeat (2) @(negedge clk);
    chk({tag, "_late"}, data_out, e);
    phi2 = 1'b0;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
    repeat (4) @(negedge clk);
    if (r) begin
      if (a == 2'b00 && m_q.size() != 0) void'(m_q.pop_front());
      if (a == 2'b01) m_ovf = 1'b0;
    end
    chk({tag, "_ovf"}, {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    addr = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    reset = 1'b1; ascii_code = '0; ascii_new = 1'b0;
    phi2 = 1'b0; cs = 1'b0; rw = 1'b1; addr = 2'b00;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    peek(2'b00, 8'h80, "rst_kbd");
    peek(2'b01, 8'h00, "rst_cr");
    chk("rst_ovf", {7'b0, overflow}, 8'h00);

    // Single key 'A'
    push_key(7'h41);
    peek(2'b01, 8'h80, "a_cr");
    peek(2'b00, 8'hC1, "a_kbd");
    bus_cycle(2'b00, 1'b1, "a_read");
    peek(2'b01, 8'h00, "a_cr_after");

    // Ordered type-ahead
    push_key(7'h48); push_key(7'h49); push_key(7'h0D);
    peek(2'b00, 8'hC8, "h_kbd");
    bus_cycle(2'b00, 1'b1, "h_read");
    peek(2'b00, 8'hC9, "i_kbd");
    bus_cycle(2'b00, 1'b1, "i_read");
    peek(2'b00, 8'h8D, "cr_kbd");
    bus_cycle(2'b00, 1'b1, "cr_read");
    peek(2'b00, 8'h80, "hic_empty");

    // Overflow on fifth key
    for (int i = 0; i < 5; i++) push_key(7'(8'h61 + i));
    chk("ovf_set", {7'b0, overflow}, 8'h01);
    peek(2'b01, 8'hC0, "ovf_cr");
    for (int i = 0; i < 4; i++) begin
      peek(2'b00, 8'(8'hE1 + i), "ovf_head");
      bus_cycle(2'b00, 1'b1, "ovf_read");
    end
    peek(2'b00, 8'h80, "ovf_lost5");
    bus_cycle(2'b01, 1'b1, "ovf_clear");
    chk("ovf_cleared", {7'b0, overflow}, 8'h00);

    // Push aligned with pop on a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) push_key(7'(8'h10 + i));
    @(negedge clk);
    addr = 2'b00; rw = 1'b1; cs = 1'b1; phi2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("align_head", data_out, 8'h90);
    phi2 = 1'b0;
    @(negedge clk);
    ascii_code = 7'h55; ascii_new = 1'b1; cs = 1'b0;
    repeat (3) @(negedge clk);
    ascii_new = 1'b0;
    repeat (3) @(negedge clk);
    void'(m_q.pop_front());
    m_q.push_back(7'h55);
    chk("align_ovf", {7'b0, overflow}, 8'h00);
    peek(2'b01, 8'h80, "align_cr");
    for (int i = 0; i < 4; i++) bus_cycle(2'b00, 1'b1, "align_read");
    peek(2'b01, 8'h00, "align_cnt4");

    // Reset during a KBD read
    do_reset();
    push_key(7'h31); push_key(7'h32);
    @(negedge clk);
    addr = 2'b00; rw = 1'b1; cs = 1'b1; phi2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    phi2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; cs = 1'b0;
    m_q.delete(); m_ovf = 1'b0;
    repeat (5) @(negedge clk);
    peek(2'b01, 8'h00, "rstrd_cr");
    peek(2'b00, 8'h80, "rstrd_kbd");

    // ascii_new held high: one key only
    @(negedge clk);
    ascii_code = 7'h5A; ascii_new = 1'b1;
    repeat (100) @(negedge clk);
    ascii_new = 1'b0;
    repeat (3) @(negedge clk);
    m_q.push_back(7'h5A);
    peek(2'b00, 8'hDA, "hold_kbd");
    bus_cycle(2'b00, 1'b1, "hold_read");
    peek(2'b01, 8'h00, "hold_once");

    // Random mix of keys, reads and ignored writes
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0, 1: push_key(7'($urandom_range(0, 127)));
        2:    bus_cycle(2'($urandom_range(0, 3)), 1'b1, "rnd_rd");
        default: bus_cycle(2'($urandom_range(0, 3)), 1'b0, "rnd_wr");
      endcase
      peek(2'b00, exp_data(2'b00), "rnd_kbd");
      peek(2'b01, exp_data(2'b01), "rnd_cr");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/apple1_kbd_port.md
# apple1_kbd_port

Keyboard-side port of the Apple-1 PIA emulation, downstream of `ps2_keyboard_to_ascii`. Captures each 7-bit ASCII code announced on `ascii_new` into a small type-ahead FIFO. Presents the Apple-1 KBD ($D010) and KBDCR ($D011) registers to the 6502 bus. A completed CPU read of KBD pops one character.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ascii_code`  in  7  code from keyboard decoder; valid when `ascii_new` rises.
- `ascii_new`  in  1  new-code indication, `clk` domain; each 0→1 transition is one key.
- `phi2`  in  1  6502 phase-2 clock, asynchronous to `clk`.
- `cs`  in  1  chip select for $D010–$D013.
- `rw`  in  1  6502 R/W̄ (1 = read).
- `addr`  in  2  A1:A0.
- `data_out`  out  8  read data, combinational from current state.
- `overflow`  out  1  sticky: a key was dropped on a full FIFO.

## Operation
- Push: the cycle after `ascii_new` is sampled 1 with previous sample 0, write `ascii_code` at the tail if not full.
- Push onto a full FIFO: drop the key and set `overflow`.
- Bus qualification:
  - `phi2` passes through a 2-flop synchronizer; its falling edge is detected on the synced signal.
  - While synced `phi2`=1 and `cs`=1 and `rw`=1, set `rd_kbd_pend` if `addr`=00 and `rd_cr_pend` if `addr`=01.
  - On the synced falling edge: if `rd_kbd_pend` and FIFO not empty, pop one entry. If `rd_cr_pend`, clear `overflow`. Both pend flags clear on that edge.
- Read data when `addr`[1]=0:
  - addr 00: `{1'b1, head}`, or 8'h80 when empty. Bit 7 is always 1, as the Woz monitor expects.
  - addr 01: `{~empty, overflow, 6'b0}`.
  - `addr`[1]=1 (display registers, not this block): 8'h00.
- `data_out` does not depend on `cs`/`rw`; the bus mux gates it.
- Writes are ignored, including the monitor's KBDCR init write of $A7.

## Timing
- Reset: FIFO empty (pointers 0, count 0), `overflow`=0, synchronizer flops 0, edge-detect history 0, pend flags 0. `data_out` is therefore 8'h80 at addr 00 and 8'h00 at addr 01.
- Push latency: the KBDCR bit 7 rise and the new head are visible 1 `clk` after the cycle in which the `ascii_new` edge is sampled.
- Pop latency: 3 `clk` after `phi2` falls at the pin (2 sync + 1 edge). `data_out` stays unchanged throughout the read's `phi2`-high window.
- Holding `ascii_new` high gives one push only; a new push requires a return to 0.
- Same-cycle push and pop:
  - Both take effect; count is unchanged.
  - When full, the pop frees a slot, so the push is accepted with no overflow.
  - When empty, there is no pop and the push proceeds.
- Pop on empty: no-op; pointers do not move.
- Pointers wrap modulo `DEPTH`. Count width is clog2(`DEPTH`)+1, so full and empty are distinguishable.
- `reset` asserted mid-read: pend flags and FIFO clear immediately; the outstanding read has no side effect.
- Each `phi2` high phase causes at most one pop. Bus signals are sampled only while synced `phi2`=1.

## Structure
- Package `apple1_kbd_pkg` holds:
  - `KBD_ADDR`=2'b00, `KBDCR_ADDR`=2'b01
  - `KBD_EMPTY`=8'h80
  - `KBDCR_READY_BIT`=7, `KBDCR_OVF_BIT`=6
- Sub-module `kbd_fifo`: synchronous FIFO with parameters `WIDTH`=7 and `DEPTH`; ports push, pop, din, dout (head), empty, full.
- Top level holds the synchronizer, the edge detectors, the pend flags, the overflow flag and the read mux.

## Test plan
- After reset, read addr 00 and 01 → 8'h80 and 8'h00; `overflow`=0.
- Pulse `ascii_new` with 7'h41 ('A'), then read KBDCR → 8'h80. Read KBD → 8'hC1. After that read's `phi2` fall plus 3 clk, KBDCR → 8'h00.
- Push 7'h48, 7'h49, 7'h0D; three KBD reads → 8'hC8, 8'hC9, 8'h8D, in order; then empty.
- Push 5 keys with `DEPTH`=4:
  - `overflow`=1 and KBDCR=8'hC0.
  - The first 4 codes read back in order; the 5th is lost.
  - A KBDCR read clears `overflow`.
- With the FIFO full, align the `ascii_new` edge with the KBD-read pop cycle → no overflow, count stays 4, and the new code is last out.
- Assert `reset` while `phi2` is high during a KBD read with 2 entries → FIFO empty and no pop after release. Holding `ascii_new` high for 100 clk gives exactly one push.
